// File: rtl/rgmii_cal_pkg.sv
// Shared FSM state types and frame-format constants for RGMII RX delay calibration.
// Latency: none (declarations only).
// Backpressure: none.
package rgmii_cal_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SET_TAP,
    ST_SETTLE,
    ST_ARM,
    ST_MEASURE,
    ST_NEXT,
    ST_SEARCH,
    ST_DONE,
    ST_FAIL
  } cal_state_e;

  typedef enum logic [1:0] {
    CHK_IDLE,
    CHK_PRE,
    CHK_BODY
  } chk_state_e;

  localparam logic [7:0] PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0] SFD_BYTE        = 8'hD5;
  localparam int         MIN_FRAME_BYTES = 64;

endpackage

// File: rtl/gmii_preamble_checker.sv
// Scores each GMII frame (dv rise to dv fall) as good or bad by preamble/SFD/length integrity.
// Latency: one good or bad pulse, registered, on the cycle after dv is first seen low.
// Backpressure: none; observes the stream passively and restarts on every dv rise.
module gmii_preamble_checker
  import rgmii_cal_pkg::*;
#(
  parameter int MIN_PRE = 5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dv_i,
  input  logic [7:0] rxd_i,
  output logic       frame_good_o,
  output logic       frame_bad_o
);

  localparam logic [7:0] MIN_PRE_B = 8'(MIN_PRE);
  localparam logic [6:0] BODY_MIN  = 7'(MIN_FRAME_BYTES);

  chk_state_e state_q, state_d;
  logic [7:0] pre_cnt_q, pre_cnt_d;
  logic [6:0] body_cnt_q, body_cnt_d;
  logic       err_q, err_d;
  logic       good_q, good_d;
  logic       bad_q, bad_d;

  // Frame parser: preamble counting with a sticky error flag, then body length up to the minimum.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    body_cnt_d = body_cnt_q;
    err_d      = err_q;
    good_d     = 1'b0;
    bad_d      = 1'b0;
    case (state_q)
      CHK_IDLE: begin
        if (dv_i) begin
          state_d   = CHK_PRE;
          err_d     = (rxd_i != PREAMBLE_BYTE);
          pre_cnt_d = (rxd_i == PREAMBLE_BYTE) ? 8'd1 : 8'd0;
        end
      end
      CHK_PRE: begin
        if (!dv_i) begin
          // dv fell before a valid SFD was accepted
          bad_d   = 1'b1;
          state_d = CHK_IDLE;
        end else if (!err_q) begin
          if (rxd_i == PREAMBLE_BYTE) begin
            if (pre_cnt_q != 8'hFF) pre_cnt_d = pre_cnt_q + 8'd1;
          end else if (rxd_i == SFD_BYTE && pre_cnt_q >= MIN_PRE_B) begin
            state_d    = CHK_BODY;
            body_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CHK_BODY: begin
        if (!dv_i) begin
          good_d  = (body_cnt_q >= BODY_MIN);
          bad_d   = (body_cnt_q < BODY_MIN);
          state_d = CHK_IDLE;
        end else if (body_cnt_q < BODY_MIN) begin
          body_cnt_d = body_cnt_q + 7'd1;
        end
      end
      default: state_d = CHK_IDLE;
    endcase
  end

  // State and pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CHK_IDLE;
      pre_cnt_q  <= '0;
      body_cnt_q <= '0;
      err_q      <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      body_cnt_q <= body_cnt_d;
      err_q      <= err_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
    end
  end

  assign frame_good_o = good_q;
  assign frame_bad_o  = bad_q;

endmodule

// File: rtl/rgmii_rx_delay_cal.sv
// Sweeps all RX delay taps, scores each by frame integrity and applies the centre of the widest passing window.
// Latency: NUM_TAPS*(2+SETTLE_CYC+ARM+MEASURE) + NUM_TAPS search cycles from cal_start to done/fail.
// Backpressure: none; cal_start is ignored while busy and frames are only observed.
module rgmii_rx_delay_cal
  import rgmii_cal_pkg::*;
#(
  parameter int TAP_W          = 5,
  parameter int DEFAULT_TAP    = 0,
  parameter int SETTLE_CYC     = 16,
  parameter int FRAMES_PER_TAP = 4,
  parameter int TAP_TIMEOUT    = 1_250_000,
  parameter int MIN_PRE        = 5,
  parameter int MIN_RUN        = 3
) (
  input  logic                 gmii_rx_clk,
  input  logic                 rst,
  input  logic                 cal_start,
  input  logic                 gmii_rx_dv,
  input  logic [7:0]           gmii_rxd,
  output logic                 dly_en,
  output logic [TAP_W-1:0]     dly_tap,
  output logic                 cal_busy,
  output logic                 cal_done,
  output logic                 cal_fail,
  output logic [2**TAP_W-1:0]  pass_map,
  output logic [TAP_W:0]       eye_width
);

  localparam int NUM_TAPS = 2**TAP_W;
  localparam int LEN_W    = TAP_W + 1;
  localparam int TMO_W    = $clog2(TAP_TIMEOUT + 1);
  localparam int SET_W    = $clog2(SETTLE_CYC + 1);
  localparam int FCNT_W   = $clog2(FRAMES_PER_TAP + 1);

  cal_state_e          state_q, state_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [TAP_W-1:0]    dly_tap_q, dly_tap_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [NUM_TAPS-1:0] pass_map_q, pass_map_d;
  logic [LEN_W-1:0]    eye_q, eye_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [TAP_W-1:0]    idx_q, idx_d;
  logic [TAP_W-1:0]    cur_start_q, cur_start_d, best_start_q, best_start_d;
  logic [LEN_W-1:0]    cur_len_q, cur_len_d, best_len_q, best_len_d;
  logic                dv_q;
  logic [TAP_W-1:0]    run_start, nb_start;
  logic [LEN_W-1:0]    run_len, nb_len;
  logic                frame_good, frame_bad;

  gmii_preamble_checker #(
    .MIN_PRE (MIN_PRE)
  ) u_chk (
    .clk_i        (gmii_rx_clk),
    .rst_i        (rst),
    .dv_i         (gmii_rx_dv),
    .rxd_i        (gmii_rxd),
    .frame_good_o (frame_good),
    .frame_bad_o  (frame_bad)
  );

  // Sweep FSM next-state, per-tap scoring and serial longest-run search.
  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    dly_tap_d    = dly_tap_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    pass_map_d   = pass_map_q;
    eye_d        = eye_q;
    settle_d     = settle_q;
    fcnt_d       = fcnt_q;
    tmo_d        = tmo_q;
    idx_d        = idx_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    run_start    = cur_start_q;
    run_len      = '0;
    nb_start     = best_start_q;
    nb_len       = best_len_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (cal_start) begin
          state_d    = ST_SET_TAP;
          tap_d      = '0;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          pass_map_d = '0;
          busy_d     = 1'b1;
        end
      end
      ST_SET_TAP: begin
        dly_tap_d = tap_q;
        fcnt_d    = '0;
        tmo_d     = '0;
        settle_d  = '0;
        state_d   = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYC - 1)) state_d = ST_ARM;
        else settle_d = settle_q + 1'b1;
      end
      ST_ARM: begin
        // Two low dv samples: the checker verdict for a frame that straddled the
        // tap change lands while still in ARM and is dropped.
        if (!gmii_rx_dv && !dv_q) state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (frame_good) begin
          if (fcnt_q != FCNT_W'(FRAMES_PER_TAP)) fcnt_d = fcnt_q + 1'b1;
          if (fcnt_q >= FCNT_W'(FRAMES_PER_TAP - 1)) begin
            pass_map_d[tap_q] = 1'b1;
            state_d           = ST_NEXT;
          end
        end else if (frame_bad) begin
          pass_map_d[tap_q] = 1'b0;
          state_d           = ST_NEXT;
        end else if (tmo_q == TMO_W'(TAP_TIMEOUT - 1)) begin
          pass_map_d[tap_q] = 1'b0;
          state_d           = ST_NEXT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_NEXT: begin
        if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
          state_d      = ST_SEARCH;
          idx_d        = '0;
          cur_start_d  = '0;
          cur_len_d    = '0;
          best_start_d = '0;
          best_len_d   = '0;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = ST_SET_TAP;
        end
      end
      ST_SEARCH: begin
        if (pass_map_q[idx_q]) begin
          run_start = (cur_len_q == '0) ? idx_q : cur_start_q;
          run_len   = cur_len_q + 1'b1;
        end
        // Strictly longer only, so the earliest window keeps a tie.
        if (run_len > best_len_q) begin
          nb_start = run_start;
          nb_len   = run_len;
        end
        cur_start_d  = run_start;
        cur_len_d    = run_len;
        best_start_d = nb_start;
        best_len_d   = nb_len;
        if (idx_q == TAP_W'(NUM_TAPS - 1)) begin
          busy_d = 1'b0;
          eye_d  = nb_len;
          if (nb_len >= LEN_W'(MIN_RUN)) begin
            dly_tap_d = nb_start + TAP_W'((nb_len - 1'b1) >> 1);
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            dly_tap_d = TAP_W'(DEFAULT_TAP);
            fail_d    = 1'b1;
            state_d   = ST_FAIL;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge gmii_rx_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      dly_tap_q    <= TAP_W'(DEFAULT_TAP);
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      pass_map_q   <= '0;
      eye_q        <= '0;
      settle_q     <= '0;
      fcnt_q       <= '0;
      tmo_q        <= '0;
      idx_q        <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
      dv_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      dly_tap_q    <= dly_tap_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      pass_map_q   <= pass_map_d;
      eye_q        <= eye_d;
      settle_q     <= settle_d;
      fcnt_q       <= fcnt_d;
      tmo_q        <= tmo_d;
      idx_q        <= idx_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
      dv_q         <= gmii_rx_dv;
    end
  end

  assign dly_en    = 1'b1;
  assign dly_tap   = dly_tap_q;
  assign cal_busy  = busy_q;
  assign cal_done  = done_q;
  assign cal_fail  = fail_q;
  assign pass_map  = pass_map_q;
  assign eye_width = eye_q;

endmodule
